// File: rtl/lbp_pkg.sv
// Shared constants, types and neighbour bit order for the 3x3 LBP engine.
package lbp_pkg;
    localparam int unsigned IMG_DIM  = 128;
    localparam int unsigned COORD_W  = $clog2(IMG_DIM);
    localparam int unsigned ADDR_W   = 2 * COORD_W;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned LAST_IDX = IMG_DIM - 2;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;
    // 3x3 window indexed [col][row]; index 0 is the left column / top row
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD9,
        ST_SHIFT3,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Code bit positions of each neighbour relative to the centre pixel
    localparam int unsigned NB_UL = 0;
    localparam int unsigned NB_U  = 1;
    localparam int unsigned NB_UR = 2;
    localparam int unsigned NB_L  = 3;
    localparam int unsigned NB_R  = 4;
    localparam int unsigned NB_DL = 5;
    localparam int unsigned NB_D  = 6;
    localparam int unsigned NB_DR = 7;
endpackage

// File: rtl/lbp_if.sv
// Gray-image read port and LBP result write port of the LBP engine.
interface lbp_if;
    import lbp_pkg::*;

    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic              gray_ready;
    logic [PIX_W-1:0]  gray_data;
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [CODE_W-1:0] lbp_data;
    logic              finish;

    modport master (
        output gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish,
        input  gray_ready, gray_data
    );

    modport slave (
        input  gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish,
        output gray_ready, gray_data
    );
endinterface

// File: rtl/lbp_code.sv
// Combinational 3x3 LBP code: a neighbour bit is set when it is >= the centre.
module lbp_code
    import lbp_pkg::*;
(
    input  window_t           win_i,
    output logic [CODE_W-1:0] code_c
);
    pix_t ctr;

    assign ctr = win_i[1][1];

    always_comb begin
        code_c        = '0;
        code_c[NB_UL] = (win_i[0][0] >= ctr);
        code_c[NB_U]  = (win_i[1][0] >= ctr);
        code_c[NB_UR] = (win_i[2][0] >= ctr);
        code_c[NB_L]  = (win_i[0][1] >= ctr);
        code_c[NB_R]  = (win_i[2][1] >= ctr);
        code_c[NB_DL] = (win_i[0][2] >= ctr);
        code_c[NB_D]  = (win_i[1][2] >= ctr);
        code_c[NB_DR] = (win_i[2][2] >= ctr);
    end
endmodule

// File: rtl/lbp.sv
// Streaming LBP engine: raster-scans interior pixels with a sliding 3x3 window
// that is filled one column (three reads, top to bottom) at a time.
module lbp
    import lbp_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    lbp_if.master bus
);
    state_e                   state_q, state_d;
    coord_t                   row_q, row_d, col_q, col_d;
    coord_t                   rd_c_q, rd_c_d;
    logic [1:0]               rd_r_q, rd_r_d;
    window_t                  win_q, win_d;
    logic [1:0][PIX_W-1:0]    colbuf_q, colbuf_d;
    logic [ADDR_W-1:0]        gray_addr_q, gray_addr_d, lbp_addr_q, lbp_addr_d;
    logic                     gray_req_q, gray_req_d, lbp_valid_q, lbp_valid_d;
    logic                     finish_q, finish_d;
    logic [CODE_W-1:0]        lbp_data_q, lbp_data_d, code_c;
    coord_t                   rd_row_c;
    logic                     reading_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rd_c_q      <= '0;
            rd_r_q      <= '0;
            win_q       <= '0;
            colbuf_q    <= '0;
            gray_addr_q <= '0;
            gray_req_q  <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_valid_q <= 1'b0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_c_q      <= rd_c_d;
            rd_r_q      <= rd_r_d;
            win_q       <= win_d;
            colbuf_q    <= colbuf_d;
            gray_addr_q <= gray_addr_d;
            gray_req_q  <= gray_req_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
        end
    end

    // Next state and scan position; row/col track the centre pixel
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rd_r_d  = rd_r_q;
        rd_c_d  = rd_c_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.gray_ready) begin
                    state_d = ST_LOAD9;
                    row_d   = coord_t'(1);
                    col_d   = coord_t'(1);
                    rd_r_d  = '0;
                    rd_c_d  = '0;
                end
            end
            ST_LOAD9: begin
                if (rd_r_q == 2'd2) begin
                    rd_r_d = '0;
                    if (rd_c_q == coord_t'(2)) state_d = ST_WRITE;
                    else                       rd_c_d  = rd_c_q + coord_t'(1);
                end else begin
                    rd_r_d = rd_r_q + 2'd1;
                end
            end
            ST_SHIFT3: begin
                if (rd_r_q == 2'd2) begin
                    rd_r_d  = '0;
                    state_d = ST_WRITE;
                end else begin
                    rd_r_d = rd_r_q + 2'd1;
                end
            end
            ST_WRITE: begin
                if (col_q < coord_t'(LAST_IDX)) begin
                    state_d = ST_SHIFT3;
                    col_d   = col_q + coord_t'(1);
                    rd_c_d  = col_q + coord_t'(2);
                end else if (row_q < coord_t'(LAST_IDX)) begin
                    state_d = ST_LOAD9;
                    row_d   = row_q + coord_t'(1);
                    col_d   = coord_t'(1);
                    rd_c_d  = '0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Window capture: the third pixel of a column shifts the whole column in
    assign reading_c = (state_q == ST_LOAD9) || (state_q == ST_SHIFT3);

    always_comb begin
        win_d    = win_q;
        colbuf_d = colbuf_q;
        if (reading_c) begin
            if (rd_r_q == 2'd2) begin
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
                win_d[2] = {bus.gray_data, colbuf_q[1], colbuf_q[0]};
            end else begin
                colbuf_d[rd_r_q[0]] = bus.gray_data;
            end
        end
    end

    lbp_code u_code (
        .win_i  (win_d),
        .code_c (code_c)
    );

    // Registered outputs are loaded with the values of the upcoming state
    assign rd_row_c = row_d + coord_t'(rd_r_d) - coord_t'(1);

    always_comb begin
        gray_req_d  = (state_d == ST_LOAD9) || (state_d == ST_SHIFT3);
        gray_addr_d = gray_req_d ? {rd_row_c, rd_c_d} : gray_addr_q;
        lbp_valid_d = (state_d == ST_WRITE);
        lbp_addr_d  = lbp_valid_d ? {row_d, col_d} : lbp_addr_q;
        lbp_data_d  = lbp_valid_d ? code_c : lbp_data_q;
        finish_d    = (state_d == ST_DONE);
    end

    assign bus.gray_addr = gray_addr_q;
    assign bus.gray_req  = gray_req_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp.sv
// Four LBP engines run in lockstep on uniform, column-ramp, single-dip and random images.
module tb_lbp;
    localparam int NI    = 4;
    localparam int DIM   = 128;
    localparam int DEPTH = DIM * DIM;

    logic clk;
    logic reset;
    logic gray_ready;
    logic clr_res;

    logic [7:0] img [NI][DEPTH];
    logic [7:0] res [NI][DEPTH];
    logic       hit [NI][DEPTH];
    int         wr_cnt   [NI];
    int         dup_cnt  [NI];
    int         late_req [NI];

    logic [NI-1:0]        req_w, valid_w, fin_w;
    logic [NI-1:0][13:0]  gaddr_w, laddr_w;
    logic [NI-1:0][7:0]   ldata_w;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        lbp_if bif ();
        lbp u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bif.master)
        );
        assign bif.gray_ready = gray_ready;
        assign bif.gray_data  = bif.gray_req ? img[k][bif.gray_addr] : 8'hxx;
        assign req_w[k]   = bif.gray_req;
        assign valid_w[k] = bif.lbp_valid;
        assign fin_w[k]   = bif.finish;
        assign gaddr_w[k] = bif.gray_addr;
        assign laddr_w[k] = bif.lbp_addr;
        assign ldata_w[k] = bif.lbp_data;
    end

    // External result memories plus write/late-request bookkeeping
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (clr_res) for (int a = 0; a < DEPTH; a++) res[k][a] <= 8'h00;
            if (valid_w[k]) res[k][laddr_w[k]] <= ldata_w[k];
            if (reset) begin
                wr_cnt[k]   <= 0;
                dup_cnt[k]  <= 0;
                late_req[k] <= 0;
                for (int a = 0; a < DEPTH; a++) hit[k][a] <= 1'b0;
            end else begin
                if (valid_w[k]) begin
                    wr_cnt[k] <= wr_cnt[k] + 1;
                    if (hit[k][laddr_w[k]]) dup_cnt[k] <= dup_cnt[k] + 1;
                    hit[k][laddr_w[k]] <= 1'b1;
                end
                if (fin_w[k] && req_w[k]) late_req[k] <= late_req[k] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_k%0d_gaddr", tag, k), 32'(gaddr_w[k]), 32'd0);
            check($sformatf("%s_k%0d_req", tag, k), 32'(req_w[k]), 32'd0);
            check($sformatf("%s_k%0d_laddr", tag, k), 32'(laddr_w[k]), 32'd0);
            check($sformatf("%s_k%0d_valid", tag, k), 32'(valid_w[k]), 32'd0);
            check($sformatf("%s_k%0d_ldata", tag, k), 32'(ldata_w[k]), 32'd0);
            check($sformatf("%s_k%0d_finish", tag, k), 32'(fin_w[k]), 32'd0);
        end
    endtask

    // Software reference: interior pixels get the LBP code, borders stay 0
    function automatic logic [7:0] golden(input int k, input int r, input int c);
        int         dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int         dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        logic [7:0] code;
        logic [7:0] ctr;
        if (r < 1 || r > DIM - 2 || c < 1 || c > DIM - 2) return 8'h00;
        ctr = img[k][r * DIM + c];
        for (int b = 0; b < 8; b++)
            code[b] = (img[k][(r + dr[b]) * DIM + c + dc[b]] >= ctr);
        return code;
    endfunction

    initial begin
        int cyc;
        int uni_bad, ramp_bad, fld_bad, rnd_bad;
        int border_bad [NI];
        int a;
        logic inner;

        reset      = 1'b1;
        gray_ready = 1'b0;
        clr_res    = 1'b1;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                img[0][r * DIM + c] = 8'h50;
                img[1][r * DIM + c] = 8'(c);
                img[2][r * DIM + c] = (r == 64 && c == 64) ? 8'h00 : 8'h80;
                img[3][r * DIM + c] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h80;
            end
        end

        repeat (3) @(negedge clk);
        clr_res = 1'b0;
        check_reset("por");
        reset = 1'b0;

        // Source not ready: engine must stay quiet
        repeat (20) begin
            @(negedge clk);
            check("idle_quiet", 32'({req_w, valid_w}), 32'd0);
        end

        gray_ready = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!req_w[0] && cyc < 100);
        check("start_timeout", 32'(cyc < 100), 32'd1);
        check("first_rd_addr", 32'(gaddr_w[0]), 32'd0);

        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!valid_w[0] && cyc < 100);
        check("first_wr_latency", 32'(cyc), 32'd9);
        check("first_wr_addr", 32'(laddr_w[0]), 32'd129);
        check("first_code_uni", 32'(ldata_w[0]), 32'hFF);
        check("first_code_ramp", 32'(ldata_w[1]), 32'hD6);
        check("first_code_fld", 32'(ldata_w[2]), 32'hFF);
        check("first_code_rnd", 32'(ldata_w[3]), 32'(golden(3, 1, 1)));

        // Run to the last write of row 40, then reset mid-frame for two cycles
        cyc = 0;
        while (!(valid_w[0] && laddr_w[0] == 14'(40 * DIM + 126)) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        check("row40_timeout", 32'(cyc < 30000), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("midrst1");
        @(negedge clk);
        check_reset("midrst2");
        reset = 1'b0;

        cyc = 0;
        while (!(&fin_w) && cyc < 70000) begin
            @(negedge clk);
            cyc++;
        end
        check("finish_timeout", 32'(cyc < 70000), 32'd1);
        check("frame_cycles", 32'(cyc), 32'd64261);

        gray_ready = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("k%0d_finish_sticky", k), 32'(fin_w[k]), 32'd1);
            check($sformatf("k%0d_valid_done", k), 32'(valid_w[k]), 32'd0);
            check($sformatf("k%0d_req_after_fin", k), 32'(late_req[k]), 32'd0);
            check($sformatf("k%0d_write_count", k), 32'(wr_cnt[k]), 32'd15876);
            check($sformatf("k%0d_dup_writes", k), 32'(dup_cnt[k]), 32'd0);
        end

        check("fld_64_64", 32'(res[2][64 * DIM + 64]), 32'hFF);
        check("fld_63_63", 32'(res[2][63 * DIM + 63]), 32'h7F);
        check("fld_65_65", 32'(res[2][65 * DIM + 65]), 32'hFE);
        check("fld_63_64", 32'(res[2][63 * DIM + 64]), 32'hBF);
        check("ramp_last", 32'(res[1][16254]), 32'hD6);
        check("uni_corner", 32'(res[0][0]), 32'h00);

        uni_bad = 0; ramp_bad = 0; fld_bad = 0; rnd_bad = 0;
        for (int k = 0; k < NI; k++) border_bad[k] = 0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a     = r * DIM + c;
                inner = (r >= 1 && r <= DIM - 2 && c >= 1 && c <= DIM - 2);
                if (!inner) begin
                    for (int k = 0; k < NI; k++)
                        if (res[k][a] !== 8'h00) border_bad[k]++;
                end else begin
                    if (res[0][a] !== 8'hFF) uni_bad++;
                    if (res[1][a] !== 8'hD6) ramp_bad++;
                    if (!(r >= 63 && r <= 65 && c >= 63 && c <= 65) && res[2][a] !== 8'hFF)
                        fld_bad++;
                end
                if (res[3][a] !== golden(3, r, c)) rnd_bad++;
            end
        end
        check("uni_interior_bad", 32'(uni_bad), 32'd0);
        check("ramp_interior_bad", 32'(ramp_bad), 32'd0);
        check("fld_far_bad", 32'(fld_bad), 32'd0);
        check("rnd_golden_bad", 32'(rnd_bad), 32'd0);
        for (int k = 0; k < NI; k++)
            check($sformatf("k%0d_border_bad", k), 32'(border_bad[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lbp.md
Name: lbp

Overview:
- Computes the 3x3 Local Binary Pattern (LBP) code for a 128x128 8-bit grayscale image.
- Reads pixels from an external gray-image memory through a request/address port.
- Writes one 8-bit LBP code per interior pixel to an external result memory, then raises finish.
- Sits between the image source memory and the LBP result memory as a single-pass streaming engine.

Parameters:
- IMG_DIM, 128, image width and height in pixels (square image; power of two). Address width is fixed at 14 bits for the default.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- gray_addr  output  14  pixel address, row*IMG_DIM + col.
- gray_req  output  1  read request; gray_data is valid for gray_addr in the same cycle.
- gray_ready  input  1  source memory ready; processing starts only when it is high.
- gray_data  input  8  pixel value for gray_addr; sampled at the rising edge ending a gray_req cycle.
- lbp_addr  output  14  result address (same mapping as gray_addr).
- lbp_valid  output  1  write strobe; external memory captures lbp_data at lbp_addr while high.
- lbp_data  output  8  LBP code.
- finish  output  1  frame complete; sticky until reset.

Behaviour:
- Reset values: gray_addr=0, gray_req=0, lbp_addr=0, lbp_valid=0, lbp_data=0, finish=0; FSM goes to IDLE.
- All outputs are registered and change only on rising clk.
- Read timing: source drives gray_data mid-cycle for the gray_addr of that cycle. DUT captures it at the following rising edge. Zero wait states. gray_data is undefined (may be Z) when gray_req=0.
- LBP code for center gc at (r,c), neighbour bit = 1 when gp >= gc (unsigned compare):
  - bit0 (r-1,c-1), bit1 (r-1,c), bit2 (r-1,c+1), bit3 (r,c-1)
  - bit4 (r,c+1), bit5 (r+1,c-1), bit6 (r+1,c), bit7 (r+1,c+1)
- Scope: only interior pixels, r and c in 1..IMG_DIM-2, raster order, are written. 126*126 = 15876 writes.
- Border addresses are never written; the result memory is pre-cleared to 0, so border codes read as 0.
- FSM states:
  - IDLE: wait for gray_ready=1.
  - LOAD9: 9 reads, filling the 3x3 window at the start of each row (c=1).
  - SHIFT3: shift the window left and read the 3 pixels of the new right column (r-1,r,r+1 at c+1).
  - WRITE: one cycle with lbp_valid=1, lbp_addr = center address, lbp_data = code.
  - Then SHIFT3 if c < IMG_DIM-2; else LOAD9 on the next row if r < IMG_DIM-2; else DONE.
  - DONE: finish=1, gray_req=0, lbp_valid=0; hold until reset.
- gray_req=1 exactly in read cycles. lbp_valid is a single-cycle pulse per result; never two writes to the same address.
- finish rises the cycle after the last write (address (IMG_DIM-2)*IMG_DIM + IMG_DIM-2 = 16254). gray_ready may drop after finish.
- gray_ready low mid-frame: ignored after start (source holds it high until finish).
- Reset mid-operation: abort immediately, all outputs to reset values, and restart from (1,1) once gray_ready is high. Already-written results are not cleared.
- Pixel values are unsigned 8-bit; an equal neighbour sets its bit.

Decomposition:
- Shared package lbp_pkg: IMG_DIM, address width, FSM state enum, neighbour bit-order constants.
- One sub-module, lbp_code: combinational, 9x8-bit window in, 8-bit code out (8 comparators).
- Addressing, window registers and FSM stay in the top.

Test Plan:
- Uniform image, all 0x50 -> every interior code 0xFF; all 508 border entries 0x00; finish asserted; exactly 15876 lbp_valid pulses.
- Column ramp, pixel = col -> every interior code 0xD6.
- Field of 0x80 with pixel (64,64)=0x00:
  - (64,64) -> 0xFF
  - (63,63) -> 0x7F
  - (65,65) -> 0xFE
  - (63,64) -> 0xBF
  - all other interior pixels -> 0xFF
- Random image vs software golden model -> 0 mismatches over all 16384 addresses. gray_req never asserted after finish.
- Hold gray_ready=0 for 20 cycles after reset -> gray_req and lbp_valid stay 0. Start on gray_ready=1 -> first read address 0, first write address 129.
- Assert reset for 2 cycles mid-frame (after row 40) -> outputs at reset values. Re-run completes with golden-correct results and finish=1.
